// File: rtl/sort_arbiter_pkg.sv
// Shared definitions for the sort arbiter block.
//   state_e      : arbiter FSM state encoding
//   DefN/DefW    : default elements per job and element width
//   DefTimeout   : default sorter completion budget in cycles
//   ErrCountW    : width of the saturating timeout counter output
package sort_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StWait   = 2'd2,
    StResp   = 2'd3
  } state_e;

  localparam int unsigned DefN       = 4;
  localparam int unsigned DefW       = 8;
  localparam int unsigned DefTimeout = 64;
  localparam int unsigned ErrCountW  = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   req0, req1 : request lines
//   en         : a grant is being taken this cycle; updates last_grant
//   gnt_valid  : at least one request is present
//   gnt_id     : requester that wins this cycle (0/1)
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic gnt_valid,
  output logic gnt_id
);

  // Resets to 1 so that requester 0 wins the first contested round.
  logic last_grant;

  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) begin
      gnt_id = ~last_grant;
    end else begin
      gnt_id = req1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (en && gnt_valid) begin
      last_grant <= gnt_id;
    end
  end

endmodule

// File: rtl/sort_arbiter.sv
// Arbitrates two requesters onto one shared external sorter and returns results.
//   clk, rst                 : clock, synchronous active-high reset
//   req0/1, data0/1          : job requests with packed unsorted words
//   ack0/1                   : one-cycle accept pulse to the granted requester
//   resp_valid/id/data/err   : one-cycle result strobe, owner, sorted word, timeout flag
//   busy                     : high whenever a job is in flight
//   srt_start, srt_data_in   : launch pulse and job word to the sorter
//   srt_data_out, srt_done   : sorter result and completion level
//   err_count                : saturating count of timed-out jobs
module sort_arbiter
  import sort_arbiter_pkg::*;
#(
  parameter int unsigned N       = DefN,
  parameter int unsigned W       = DefW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [N*W-1:0]       data0,
  input  logic [N*W-1:0]       data1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 resp_valid,
  output logic                 resp_id,
  output logic [N*W-1:0]       resp_data,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 srt_start,
  output logic [N*W-1:0]       srt_data_in,
  input  logic [N*W-1:0]       srt_data_out,
  input  logic                 srt_done,
  output logic [ErrCountW-1:0] err_count
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e        state;
  logic          owner;
  logic          done_prev;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_inc;
  logic          accept;
  logic          gnt_valid;
  logic          gnt_id;
  logic          done_edge;
  logic          expired;

  // Grants are only taken while idle; reset blocks any accept in its cycle.
  assign accept = (state == StIdle) && !rst;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .en        (accept),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign ack0 = accept && gnt_valid && !gnt_id;
  assign ack1 = accept && gnt_valid && gnt_id;

  // srt_done is a level that may linger from an earlier job; only a fresh
  // rising edge seen while waiting counts as completion.
  assign done_edge = srt_done && !done_prev;
  assign tmo_inc   = tmo_cnt + 1'b1;
  assign expired   = (tmo_inc == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    done_prev <= srt_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      owner       <= 1'b0;
      tmo_cnt     <= '0;
      busy        <= 1'b0;
      srt_start   <= 1'b0;
      srt_data_in <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      err_count   <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (gnt_valid) begin
            state       <= StLaunch;
            owner       <= gnt_id;
            srt_data_in <= gnt_id ? data1 : data0;
            busy        <= 1'b1;
            srt_start   <= 1'b1;
          end
        end
        StLaunch: begin
          state     <= StWait;
          srt_start <= 1'b0;
          tmo_cnt   <= '0;
        end
        StWait: begin
          // Completion is checked first so a done edge on the expiry cycle wins.
          if (done_edge) begin
            state      <= StResp;
            resp_valid <= 1'b1;
            resp_id    <= owner;
            resp_data  <= srt_data_out;
            resp_err   <= 1'b0;
          end else if (expired) begin
            state      <= StResp;
            resp_valid <= 1'b1;
            resp_id    <= owner;
            resp_data  <= '0;
            resp_err   <= 1'b1;
            if (err_count != {ErrCountW{1'b1}}) begin
              err_count <= err_count + 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_inc;
          end
        end
        StResp: begin
          state      <= StIdle;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_arbiter.sv
// Self-checking bench for sort_arbiter: directed scenarios plus a randomized run,
// all checked every cycle against a job-timeline model of the block.
module tb_sort_arbiter;
  import sort_arbiter_pkg::*;

  localparam int unsigned N  = DefN;
  localparam int unsigned W  = DefW;
  localparam int unsigned TO = DefTimeout;
  localparam int unsigned D  = N * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, ack0, ack1;
  logic [D-1:0] data0, data1;
  logic         resp_valid, resp_id, resp_err, busy, srt_start, srt_done;
  logic [D-1:0] resp_data, srt_data_in, srt_data_out;
  logic [7:0]   err_count;

  logic         rq[2];
  logic [D-1:0] dq[2];
  assign req0  = rq[0];
  assign req1  = rq[1];
  assign data0 = dq[0];
  assign data1 = dq[1];

  sort_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .req1         (req1),
    .data0        (data0),
    .data1        (data1),
    .ack0         (ack0),
    .ack1         (ack1),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .busy         (busy),
    .srt_start    (srt_start),
    .srt_data_in  (srt_data_in),
    .srt_data_out (srt_data_out),
    .srt_done     (srt_done),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ascending sort of the packed elements, element 0 (smallest) in the LSBs.
  function automatic logic [D-1:0] sort_word(input logic [D-1:0] x);
    logic [W-1:0] e[N];
    logic [W-1:0] t;
    logic [D-1:0] r;
    for (int i = 0; i < N; i++) e[i] = x[i*W +: W];
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N - 1 - i; j++) begin
        if (e[j] > e[j+1]) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
      end
    end
    for (int i = 0; i < N; i++) r[i*W +: W] = e[i];
    return r;
  endfunction

  // Event logs filled by the monitor.
  int           ack_id_q[$];
  int           ack_cyc_q[$];
  int           start_cyc_q[$];
  int           resp_id_q[$];
  logic [D-1:0] resp_data_q[$];
  int           resp_err_q[$];
  int           resp_cyc_q[$];
  logic         ack_seen[2];

  // Job-timeline model: when idle, a request is taken this cycle; launch is the
  // following cycle; the job ends on a fresh done edge or TO cycles after launch.
  bit           m_idle = 1'b1;
  bit           m_last = 1'b1;
  int           m_launch = -1;
  int           m_resp_at = -1;
  int           m_owner = 0;
  logic [D-1:0] m_sdin = '0;
  int           m_rid = 0;
  logic [D-1:0] m_rdata = '0;
  int           m_rerr = 0;
  int           m_errc = 0;
  logic         m_prev_done = 1'b0;

  initial begin
    int w;
    bit e0, e1;
    forever begin
      @(negedge clk);
      ack_seen[0] = ack0;
      ack_seen[1] = ack1;
      if (rst) begin
        chk("ack0_in_reset", ack0, 0);
        chk("ack1_in_reset", ack1, 0);
        m_idle = 1'b1; m_last = 1'b1; m_launch = -1; m_resp_at = -1;
        m_sdin = '0; m_rid = 0; m_rdata = '0; m_rerr = 0; m_errc = 0;
      end else begin
        e0 = 1'b0; e1 = 1'b0; w = 0;
        if (m_idle && (req0 || req1)) begin
          w  = (req0 && req1) ? int'(!m_last) : int'(req1);
          e0 = (w == 0);
          e1 = (w == 1);
        end
        chk("ack0", ack0, e0);
        chk("ack1", ack1, e1);
        chk("busy", busy, !m_idle);
        chk("srt_start", srt_start, cyc == m_launch);
        chk("resp_valid", resp_valid, cyc == m_resp_at);
        chk("srt_data_in", srt_data_in, m_sdin);
        chk("resp_id", resp_id, m_rid);
        chk("resp_data", resp_data, m_rdata);
        chk("resp_err", resp_err, m_rerr);
        chk("err_count", err_count, m_errc);
        if (ack0 || ack1) begin
          ack_id_q.push_back(ack1 ? 1 : 0);
          ack_cyc_q.push_back(cyc);
        end
        if (srt_start) start_cyc_q.push_back(cyc);
        if (resp_valid) begin
          resp_id_q.push_back(int'(resp_id));
          resp_data_q.push_back(resp_data);
          resp_err_q.push_back(int'(resp_err));
          resp_cyc_q.push_back(cyc);
        end
        if (m_idle && (req0 || req1)) begin
          m_idle   = 1'b0;
          m_owner  = w;
          m_sdin   = (w == 1) ? data1 : data0;
          m_launch = cyc + 1;
          m_last   = (w == 1);
        end else if (!m_idle && m_resp_at < 0 && cyc > m_launch) begin
          if (srt_done && !m_prev_done) begin
            m_resp_at = cyc + 1; m_rid = m_owner; m_rdata = srt_data_out; m_rerr = 0;
          end else if (cyc - m_launch == int'(TO)) begin
            m_resp_at = cyc + 1; m_rid = m_owner; m_rdata = '0; m_rerr = 1;
            if (m_errc < 255) m_errc++;
          end
        end else if (cyc == m_resp_at) begin
          m_idle = 1'b1; m_resp_at = -1;
        end
      end
      m_prev_done = srt_done;
    end
  end

  // Sorter model: mode 0 asserts done K cycles after start, mode 1 never,
  // mode 2 leaves done entirely to the main sequence.
  int s_mode = 0;
  int s_k = 5;
  bit rand_k = 1'b0;
  int s_cnt = 0;
  bit rand_mode = 1'b0;
  int jobs_left[2] = '{0, 0};

  task automatic sorter_step();
    if (srt_start && s_mode != 2) begin
      srt_done = 1'b0;
      s_cnt = (s_mode == 1) ? 0 : (rand_k ? int'($urandom_range(1, 70)) : s_k);
    end else if (s_cnt > 0) begin
      s_cnt--;
      if (s_cnt == 0) begin
        srt_done     = 1'b1;
        srt_data_out = sort_word(srt_data_in);
      end
    end
  endtask

  task automatic req_step();
    for (int i = 0; i < 2; i++) begin
      if (rq[i] && ack_seen[i]) begin
        jobs_left[i]--;
        if (jobs_left[i] > 0 && (!rand_mode || $urandom_range(0, 1) != 0)) dq[i] = $urandom;
        else rq[i] = 1'b0;
      end else if (!rq[i] && jobs_left[i] > 0 && (!rand_mode || $urandom_range(0, 2) == 0)) begin
        rq[i] = 1'b1;
        dq[i] = $urandom;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sorter_step();
    req_step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_resp(input string name, input int target, input int budget);
    int n = 0;
    while (resp_id_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, resp_id_q.size(), target);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0, s0, rise;
    rst = 1'b1;
    rq[0] = 1'b0; rq[1] = 1'b0; dq[0] = '0; dq[1] = '0;
    srt_done = 1'b0; srt_data_out = '0;
    ack_seen[0] = 1'b0; ack_seen[1] = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_srt_data_in", srt_data_in, 0);
    chk("rst_srt_start", srt_start, 0);

    // Single job, sorter answers after 5 cycles.
    a0 = ack_id_q.size(); r0 = resp_id_q.size(); s0 = start_cyc_q.size();
    s_mode = 0; s_k = 5;
    rq[0] = 1'b1; dq[0] = 32'h12347856; jobs_left[0] = 1;
    wait_resp("t1_resp_seen", r0 + 1, 200);
    chk("t1_ack_id", ack_id_q[a0], 0);
    chk("t1_start_lat", start_cyc_q[s0] - ack_cyc_q[a0], 1);
    chk("t1_resp_lat", resp_cyc_q[r0] - ack_cyc_q[a0], 7);
    chk("t1_resp_id", resp_id_q[r0], 0);
    chk("t1_resp_data", resp_data_q[r0], 32'h78563412);
    chk("t1_resp_err", resp_err_q[r0], 0);

    // Both requesting: round-robin 0, 1, 0.
    do_reset();
    a0 = ack_id_q.size(); r0 = resp_id_q.size();
    jobs_left[0] = 2; jobs_left[1] = 1;
    rq[0] = 1'b1; dq[0] = 32'h0a0b0c0d; rq[1] = 1'b1; dq[1] = 32'h11223344;
    wait_resp("t2_resp_seen", r0 + 3, 400);
    chk("t2_ack_count", ack_id_q.size() - a0, 3);
    chk("t2_grant0", ack_id_q[a0], 0);
    chk("t2_grant1", ack_id_q[a0+1], 1);
    chk("t2_grant2", ack_id_q[a0+2], 0);

    // Sorter never answers: timeout.
    do_reset();
    r0 = resp_id_q.size(); s0 = start_cyc_q.size();
    s_mode = 1;
    rq[0] = 1'b1; dq[0] = 32'h55667788; jobs_left[0] = 1;
    wait_resp("t3_resp_seen", r0 + 1, 200);
    chk("t3_resp_err", resp_err_q[r0], 1);
    chk("t3_resp_data", resp_data_q[r0], 0);
    chk("t3_resp_lat", resp_cyc_q[r0] - start_cyc_q[s0], 65);
    chk("t3_err_count", err_count, 1);

    // Done edge lands on the expiry cycle: completion wins.
    r0 = resp_id_q.size(); s0 = start_cyc_q.size();
    s_mode = 0; s_k = int'(TO);
    rq[1] = 1'b1; dq[1] = 32'h01ff8040; jobs_left[1] = 1;
    wait_resp("t4_resp_seen", r0 + 1, 200);
    chk("t4_resp_err", resp_err_q[r0], 0);
    chk("t4_resp_data", resp_data_q[r0], 32'hff804001);
    chk("t4_resp_lat", resp_cyc_q[r0] - start_cyc_q[s0], 65);
    chk("t4_err_count", err_count, 1);

    // Done level left high from the previous job must not complete a new one.
    r0 = resp_id_q.size();
    s_mode = 0; s_k = 3;
    rq[0] = 1'b1; dq[0] = 32'h04030201; jobs_left[0] = 1;
    wait_resp("t5a_resp_seen", r0 + 1, 100);
    chk("t5a_resp_data", resp_data_q[r0], 32'h04030201);
    s_mode = 2;
    rq[1] = 1'b1; dq[1] = 32'h99887766; jobs_left[1] = 1;
    repeat (12) tick();
    chk("t5_no_early_resp", resp_id_q.size(), r0 + 1);
    srt_done = 1'b0;
    tick();
    srt_data_out = 32'hcafe0001;
    srt_done = 1'b1;
    rise = cyc;
    wait_resp("t5b_resp_seen", r0 + 2, 100);
    chk("t5b_resp_data", resp_data_q[r0+1], 32'hcafe0001);
    chk("t5b_resp_id", resp_id_q[r0+1], 1);
    chk("t5b_resp_lat", resp_cyc_q[r0+1] - rise, 1);

    // Reset in the middle of WAIT abandons the job; the request is re-acked.
    s_mode = 0; s_k = 20;
    a0 = ack_id_q.size(); r0 = resp_id_q.size(); s0 = start_cyc_q.size();
    rq[1] = 1'b1; dq[1] = 32'h31415926; jobs_left[1] = 2;
    for (int i = 0; i < 20 && start_cyc_q.size() == s0; i++) tick();
    chk("t6_started", start_cyc_q.size(), s0 + 1);
    repeat (5) tick();
    do_reset();
    #1;
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_errc_after_rst", err_count, 0);
    chk("t6_resp_data_after_rst", resp_data, 0);
    wait_resp("t6_resp_seen", r0 + 1, 200);
    chk("t6_ack_count", ack_id_q.size() - a0, 2);
    chk("t6_reack_id", ack_id_q[a0+1], 1);
    chk("t6_resp_id", resp_id_q[r0], 1);
    chk("t6_resp_err", resp_err_q[r0], 0);
    repeat (3) tick();
    chk("t6_single_resp", resp_id_q.size(), r0 + 1);

    // Randomized traffic with random sorter latency, some past the timeout.
    do_reset();
    a0 = ack_id_q.size(); r0 = resp_id_q.size();
    rand_mode = 1'b1; rand_k = 1'b1; s_mode = 0;
    jobs_left[0] = 25; jobs_left[1] = 25;
    for (int i = 0; i < 10000; i++) begin
      if (jobs_left[0] == 0 && jobs_left[1] == 0 && !busy && !rq[0] && !rq[1]) break;
      tick();
    end
    repeat (3) tick();
    chk("rand_acks", ack_id_q.size() - a0, 50);
    chk("rand_resps", resp_id_q.size() - r0, 50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sort_arbiter.md
SORT_ARBITER -- requirements
Module: sort_arbiter

Interface
REQ-001 Parameter N, default 4: elements per sort job.
REQ-002 Parameter W, default 8: element width in bits; job word width D = N*W (32 at defaults).
REQ-003 Parameter TIMEOUT, default 64: maximum cycles from sorter launch to completion.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req0, req1  in  1 each  requester job request; held high with data until acked.
REQ-007 data0, data1  in  D each  requester packed unsorted job words.
REQ-008 ack0, ack1  out  1 each  one-cycle pulse: job accepted from that requester.
REQ-009 resp_valid  out  1  one-cycle pulse: result available.
REQ-010 resp_id  out  1  requester owning the result (0/1).
REQ-011 resp_data  out  D  sorted job word.
REQ-012 resp_err  out  1  result is a timeout, not sorted data.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 srt_start  out  1  one-cycle launch pulse to the shared sorter.
REQ-015 srt_data_in  out  D  job word to the sorter, held stable from launch until back in IDLE.
REQ-016 srt_data_out  in  D  sorter result.
REQ-017 srt_done  in  1  sorter completion flag; level, may stay high between jobs.
REQ-018 err_count  out  8  saturating count of timed-out jobs.

Function
REQ-019 FSM states SHALL be IDLE, LAUNCH, WAIT, RESP.
- IDLE -> LAUNCH when any req is high.
- LAUNCH -> WAIT after exactly one cycle.
- WAIT -> RESP on completion or on timeout.
- RESP -> IDLE after exactly one cycle.
REQ-020 In IDLE with a req high: grant, pulse the granted ack in that cycle, latch the granted data into srt_data_in, record owner.
REQ-021 Arbitration: one requester high -> grant it; both high -> grant the one not granted last (round-robin); last_grant resets to 1 so req0 wins first.
REQ-022 srt_start SHALL be high only during the LAUNCH cycle.
REQ-023 Completion: srt_done high in WAIT while the registered previous-cycle srt_done is low (rising edge); a done level left over from an earlier job never completes a new one.
REQ-024 On completion, capture srt_data_out into resp_data, clear resp_err.
REQ-025 Timeout counter: cleared in LAUNCH, increments each WAIT cycle, expires when it reaches TIMEOUT.
REQ-026 On expiry: resp_data = 0, resp_err = 1, err_count += 1 saturating at 255.
REQ-027 Completion and expiry in the same cycle: completion wins, no error.
REQ-028 resp_valid SHALL be high exactly during the RESP cycle.
- resp_id, resp_data and resp_err are held until the next RESP.
REQ-029 Requests arriving while busy are not acked and stay pending; no request is dropped or accepted twice.
REQ-030 Latency: accept (IDLE) -> LAUNCH +1 cycle -> WAIT +1 -> RESP 1 cycle after the completion edge.

Reset
REQ-031 rst SHALL force: state IDLE; ack*, resp_valid, resp_id, resp_err, srt_start, busy, err_count = 0; resp_data, srt_data_in = 0; last_grant = 1; timeout counter = 0.
REQ-032 rst mid-job SHALL abandon the job with no response and no ack.
- The requester's req stays high and the job is re-arbitrated after reset.
REQ-033 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding and the default N, W and TIMEOUT constants.
REQ-035 One sub-module rr_arbiter2 SHALL hold the two-way round-robin grant and the last_grant register.
REQ-036 The sorter SHALL be external to this block, connected only through the srt_* ports.

Verification (bench sorter model: asserts done K cycles after start)
REQ-037 req0 = 1, data0 = 32'h12347856, model K = 5, returns 32'h78563412 -> ack0 on the accept cycle, srt_start 1 cycle later, resp_valid with resp_id = 0, resp_data = 32'h78563412, resp_err = 0.
REQ-038 req0 and req1 high together for 3 jobs -> grant order 0, 1, 0; each ack pulsed exactly once per job.
REQ-039 Model never asserts done, TIMEOUT = 64 -> resp_valid at WAIT cycle 64 with resp_err = 1, resp_data = 0, err_count = 1.
REQ-040 Model keeps srt_done high from the prior job -> no completion until done falls and rises again.
REQ-041 rst pulsed during WAIT -> all outputs 0, no resp_valid; the still-high req is re-acked after reset.
REQ-042 Done edge on the same cycle as timeout expiry -> resp_err = 0, err_count unchanged.
